// File: rtl/cnn_pkg.sv
// Shared types and elaboration-time helpers for the CNN datapath blocks.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOADF,
        LOADA,
        CONV,
        EMIT,
        DONE
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Index width for a storage array of the given depth; never zero.
    function automatic int idx_width(input int depth);
        return (depth <= 1) ? 1 : clog2(depth);
    endfunction

    function automatic int out_size(input int a_size, input int f_size,
                                    input int pad, input int stride);
        return (a_size + 2 * pad - f_size) / stride + 1;
    endfunction

    function automatic bit ow_ok(input int ow, input int dw, input int fw, input int f_size);
        return ow >= dw + fw + clog2(f_size * f_size);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate: one DW x FW product per enabled cycle,
// sign-extended into an OW-bit accumulator with synchronous clear.
module conv_mac #(
    parameter int DW = 8,
    parameter int FW = 8,
    parameter int OW = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 en,
    input  logic signed [DW-1:0] pixel,
    input  logic signed [FW-1:0] coef,
    output logic signed [OW-1:0] acc
);

    logic signed [DW+FW-1:0] prod;
    logic signed [OW-1:0]    prod_ext;

    assign prod     = pixel * coef;
    assign prod_ext = OW'(prod);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/conv2d_engine.sv
// Serial-load 2-D convolution engine: captures a filter and an activation map,
// then streams the output feature map one result per out_valid/out_ready handshake.
//
// state | meaning
// IDLE  | waiting for go
// LOADF | capturing F_SIZE^2 filter coefficients
// LOADA | capturing A_SIZE^2 activation pixels
// CONV  | one multiply-accumulate tap per cycle
// EMIT  | result presented, waiting for out_ready
// DONE  | one-cycle completion pulse
module conv2d_engine
    import cnn_pkg::*;
#(
    parameter int DW     = 8,
    parameter int FW     = 8,
    parameter int A_SIZE = 6,
    parameter int F_SIZE = 3,
    parameter int STRIDE = 1,
    parameter int PAD    = 0,
    parameter int RELU   = 0,
    parameter int OW     = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic [FW-1:0] f_in,
    input  logic          f_valid,
    input  logic [DW-1:0] a_in,
    input  logic          a_valid,
    output logic [OW-1:0] out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam int O   = out_size(A_SIZE, F_SIZE, PAD, STRIDE);
    localparam int FN  = F_SIZE * F_SIZE;
    localparam int AN  = A_SIZE * A_SIZE;
    localparam int LW  = clog2(((AN > FN) ? AN : FN) + 1);
    localparam int FIW = clog2(F_SIZE + 1);
    localparam int OIW = clog2(O + 1);
    localparam int CW  = clog2(A_SIZE + 2 * PAD + 1) + 1;
    localparam int FAW = idx_width(FN);
    localparam int AAW = idx_width(AN);

    generate
        if (!ow_ok(OW, DW, FW, F_SIZE)) begin : g_ow_check
            $error("conv2d_engine: OW is narrower than DW+FW+clog2(F_SIZE^2)");
        end
    endgenerate

    state_t               state, nstate;
    logic [LW-1:0]        ld_cnt;
    logic [FIW-1:0]       tap_i, tap_j;
    logic [OIW-1:0]       out_r, out_c;
    logic [FW-1:0]        fmem [FN];
    logic [DW-1:0]        amem [AN];
    logic signed [CW-1:0] prow, pcol;
    logic                 in_map;
    logic [DW-1:0]        pix_sel;
    logic [FW-1:0]        coef_sel;
    logic                 last_tap, last_out;
    logic                 mac_clr, mac_en;
    logic signed [OW-1:0] acc;

    assign last_tap = (tap_i == FIW'(F_SIZE - 1)) && (tap_j == FIW'(F_SIZE - 1));
    assign last_out = (out_r == OIW'(O - 1)) && (out_c == OIW'(O - 1));

    // Padding taps land on negative or past-the-edge coordinates and read as zero.
    assign prow = CW'(out_r) * CW'(STRIDE) + CW'(tap_i) - CW'(PAD);
    assign pcol = CW'(out_c) * CW'(STRIDE) + CW'(tap_j) - CW'(PAD);

    assign in_map = !prow[CW-1] && !pcol[CW-1]
                 && (prow[CW-2:0] < (CW-1)'(A_SIZE))
                 && (pcol[CW-2:0] < (CW-1)'(A_SIZE));

    assign pix_sel  = in_map ? amem[AAW'(prow[CW-2:0]) * AAW'(A_SIZE) + AAW'(pcol[CW-2:0])]
                             : '0;
    assign coef_sel = fmem[FAW'(tap_i) * FAW'(F_SIZE) + FAW'(tap_j)];

    always_comb begin
        nstate  = state;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        case (state)
            IDLE: begin
                if (go) nstate = LOADF;
            end
            LOADF: begin
                if (f_valid && (ld_cnt == LW'(FN - 1))) nstate = LOADA;
            end
            LOADA: begin
                if (a_valid && (ld_cnt == LW'(AN - 1))) begin
                    nstate  = CONV;
                    mac_clr = 1'b1;
                end
            end
            CONV: begin
                mac_en = 1'b1;
                if (last_tap) nstate = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_out) begin
                        nstate = DONE;
                    end else begin
                        nstate  = CONV;
                        mac_clr = 1'b1;
                    end
                end
            end
            DONE: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ld_cnt <= '0;
            tap_i  <= '0;
            tap_j  <= '0;
            out_r  <= '0;
            out_c  <= '0;
        end else begin
            state <= nstate;
            case (state)
                IDLE: begin
                    ld_cnt <= '0;
                    tap_i  <= '0;
                    tap_j  <= '0;
                    out_r  <= '0;
                    out_c  <= '0;
                end
                LOADF: begin
                    if (f_valid) ld_cnt <= (ld_cnt == LW'(FN - 1)) ? '0 : ld_cnt + LW'(1);
                end
                LOADA: begin
                    if (a_valid) ld_cnt <= ld_cnt + LW'(1);
                end
                CONV: begin
                    if (tap_j == FIW'(F_SIZE - 1)) begin
                        tap_j <= '0;
                        tap_i <= (tap_i == FIW'(F_SIZE - 1)) ? '0 : tap_i + FIW'(1);
                    end else begin
                        tap_j <= tap_j + FIW'(1);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_c == OIW'(O - 1)) begin
                            out_c <= '0;
                            out_r <= out_r + OIW'(1);
                        end else begin
                            out_c <= out_c + OIW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && (state == LOADF) && f_valid) fmem[FAW'(ld_cnt)] <= f_in;
        if (!reset && (state == LOADA) && a_valid) amem[AAW'(ld_cnt)] <= a_in;
    end

    conv_mac #(
        .DW (DW),
        .FW (FW),
        .OW (OW)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clear (mac_clr),
        .en    (mac_en),
        .pixel ($signed(pix_sel)),
        .coef  ($signed(coef_sel)),
        .acc   (acc)
    );

    assign out       = ((RELU != 0) && acc[OW-1]) ? '0 : acc;
    assign out_valid = (state == EMIT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule
